// File: rtl/fc_pkg.sv
// fc_pkg: FSM state, default sizes and output-stage saturate/ReLU helpers for fc_layer_param
package fc_pkg;
  localparam int FC_N_IN = 30;
  localparam int FC_N_OUT = 10;
  localparam int FC_DATA_W = 16;
  localparam int FC_FRAC_W = 8;
  localparam int FC_RELU_EN = 0;
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FINAL, S_OUT} fc_state_e;
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic signed [63:0] relu(input logic signed [63:0] v, input bit en);
    return (en && v < 0) ? 64'sd0 : v;
  endfunction
endpackage

// File: rtl/fc_mac.sv
// fc_mac: signed x*w product added to one accumulator; ports x, w (DATA_W), acc_in -> acc_out (ACC_W)
module fc_mac
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W,
  parameter int ACC_W = acc_width(FC_DATA_W, FC_N_IN)
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [ACC_W-1:0]  acc_out
);
  logic signed [2*DATA_W-1:0] prod;
  always_comb begin
    prod = (2 * DATA_W)'(x) * (2 * DATA_W)'(w);
    acc_out = acc_in + ACC_W'(prod);
  end
endmodule

// File: rtl/fc_layer_param.sv
// fc_layer_param: streamed-weight fully connected layer; ports clk, reset, in_valid/in_ready/in_vec/bias_vec, w_valid/w_ready/w_data, out_valid/out_ready/out_vec, busy, in_idx, out_idx
module fc_layer_param
  import fc_pkg::*;
#(
  parameter int N_IN = FC_N_IN,
  parameter int N_OUT = FC_N_OUT,
  parameter int DATA_W = FC_DATA_W,
  parameter int FRAC_W = FC_FRAC_W,
  parameter int RELU_EN = FC_RELU_EN
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [N_IN-1:0][DATA_W-1:0]                in_vec,
  input  logic [N_OUT-1:0][DATA_W-1:0]               bias_vec,
  input  logic                                       w_valid,
  output logic                                       w_ready,
  input  logic [DATA_W-1:0]                          w_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [N_OUT-1:0][DATA_W-1:0]               out_vec,
  output logic                                       busy,
  output logic [$clog2(N_IN > 1 ? N_IN : 2)-1:0]     in_idx,
  output logic [$clog2(N_OUT > 1 ? N_OUT : 2)-1:0]   out_idx
);
  localparam int IW = $clog2(N_IN > 1 ? N_IN : 2);
  localparam int OW = $clog2(N_OUT > 1 ? N_OUT : 2);
  localparam int ACC_W = acc_width(DATA_W, N_IN);
  localparam logic [IW-1:0] IN_LAST = IW'(N_IN - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(N_OUT - 1);
  fc_state_e state;
  logic [N_IN-1:0][DATA_W-1:0] in_q;
  logic [N_OUT-1:0][DATA_W-1:0] bias_q;
  logic signed [ACC_W-1:0] acc [N_OUT];
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W:0] sum [N_OUT];
  logic [N_OUT-1:0][DATA_W-1:0] res;
  fc_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .x(signed'(in_q[in_idx])),
    .w(signed'(w_data)),
    .acc_in(acc[out_idx]),
    .acc_out(acc_nxt)
  );
  // bias is aligned to the product scale (2*FRAC_W) before the single rescaling shift
  always_comb
    for (int j = 0; j < N_OUT; j++) begin
      sum[j] = (ACC_W + 1)'(acc[j]) + ((ACC_W + 1)'(signed'(bias_q[j])) <<< FRAC_W);
      res[j] = DATA_W'(relu(sat(64'(sum[j] >>> FRAC_W), DATA_W), RELU_EN != 0));
    end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      in_ready <= 1'b0;
      w_ready <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      in_idx <= '0;
      out_idx <= '0;
      in_q <= '0;
      bias_q <= '0;
      out_vec <= '0;
      for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
    end else
      case (state)
        S_IDLE:
          if (in_valid && in_ready) begin
            state <= S_MAC;
            in_ready <= 1'b0;
            w_ready <= 1'b1;
            busy <= 1'b1;
            in_q <= in_vec;
            bias_q <= bias_vec;
            in_idx <= '0;
            out_idx <= '0;
            for (int j = 0; j < N_OUT; j++) acc[j] <= '0;
          end else in_ready <= 1'b1;
        S_MAC:
          if (w_valid && w_ready) begin
            acc[out_idx] <= acc_nxt;
            if (out_idx == OUT_LAST) begin
              out_idx <= '0;
              if (in_idx == IN_LAST) begin
                state <= S_FINAL;
                w_ready <= 1'b0;
              end else in_idx <= in_idx + 1'b1;
            end else out_idx <= out_idx + 1'b1;
          end
        S_FINAL: begin
          state <= S_OUT;
          out_vec <= res;
          out_valid <= 1'b1;
        end
        S_OUT:
          if (out_ready) begin
            state <= S_IDLE;
            out_valid <= 1'b0;
            out_vec <= '0;
            busy <= 1'b0;
            in_ready <= 1'b1;
          end
        default: state <= S_IDLE;
      endcase
endmodule
